cong_seq: RTL and testbench

- Parametrised multi-cycle adder/subtractor for the ALU datapath; next generation of the single-bit full-adder cell.
- Processes CHUNK bits per clock using a ripple of full-adder stages, so a WIDTH-bit add/sub completes in WIDTH/CHUNK cycles.
- Start/ready/done handshake; registered sum plus carry, signed-overflow and zero flags for the ALU flag register.

---
 rtl/cong_seq.sv | 110 +++++++++++
 tb/tb_cong_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cong_seq.sv
// cong_seq: multi-cycle chunked ripple adder/subtractor with start/ready/done handshake and ALU flags.
module cong_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic c_q, c_d, co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CHUNK-1:0] sum;
  logic [WIDTH+CHUNK-1:0] sh;
  logic c, cm, last;
  // Operands shift right each cycle so the current chunk always sits in the low CHUNK bits.
  always_comb begin
    c = c_q;
    cm = c_q;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cm = c;
      sum[i] = a_q[i] ^ b_q[i] ^ c;
      c = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
  end
  assign sh   = {sum, acc_q};
  assign last = idx_q == IW'(NCH - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    acc_d = acc_q;
    idx_d = idx_q;
    s_d = s_q;
    co_d = co_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d = a;
        b_d = b ^ {WIDTH{sub}};
        c_d = sub ? ~cin : cin;
        idx_d = '0;
      end
      RUN: begin
        a_d = a_q >> CHUNK;
        b_d = b_q >> CHUNK;
        c_d = c;
        acc_d = sh[WIDTH+CHUNK-1:CHUNK];
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = DONE;
          s_d = sh[WIDTH+CHUNK-1:CHUNK];
          co_d = c;
          ovf_d = cm ^ c;
          zero_d = ~|sh[WIDTH+CHUNK-1:CHUNK];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      acc_q <= '0;
      idx_q <= '0;
      s_q <= '0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      s_q <= s_d;
      co_q <= co_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign ready = state_q == IDLE;
  assign done  = state_q == DONE;
  assign s     = s_q;
  assign co    = co_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;
endmodule

// File: tb/tb_cong_seq.sv
// tb_cong_seq: table-driven and scoreboard checks of cong_seq across four parameter sets.
module tb_cong_seq;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [3:0] st = '0;
  logic [15:0] ia = '0, ib = '0;
  logic ic = 0, isb = 0;
  logic [3:0] dn, rdy, rco, rov, rz;
  logic [7:0] s0, s2, s3;
  logic [15:0] s1;
  logic [15:0] rs [4];
  always_comb begin
    rs[0] = {8'h0, s0};
    rs[1] = s1;
    rs[2] = {8'h0, s2};
    rs[3] = {8'h0, s3};
  end
  cong_seq #(.WIDTH(8), .CHUNK(2)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .a(ia[7:0]), .b(ib[7:0]),
    .cin(ic), .sub(isb), .ready(rdy[0]), .done(dn[0]), .s(s0), .co(rco[0]), .ovf(rov[0]), .zero(rz[0]));
  cong_seq #(.WIDTH(16), .CHUNK(4)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .a(ia), .b(ib),
    .cin(ic), .sub(isb), .ready(rdy[1]), .done(dn[1]), .s(s1), .co(rco[1]), .ovf(rov[1]), .zero(rz[1]));
  cong_seq #(.WIDTH(8), .CHUNK(8)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .a(ia[7:0]), .b(ib[7:0]),
    .cin(ic), .sub(isb), .ready(rdy[2]), .done(dn[2]), .s(s2), .co(rco[2]), .ovf(rov[2]), .zero(rz[2]));
  cong_seq #(.WIDTH(8), .CHUNK(1)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .a(ia[7:0]), .b(ib[7:0]),
    .cin(ic), .sub(isb), .ready(rdy[3]), .done(dn[3]), .s(s3), .co(rco[3]), .ovf(rov[3]), .zero(rz[3]));
  typedef struct {logic [15:0] s; logic co, ovf, zero; int dc;} exp_t;
  typedef struct {logic [7:0] a, b; logic cin, sub; logic [7:0] s; logic co, ovf, zero;} vec_t;
  localparam int W  [4] = '{8, 16, 8, 8};
  localparam int NC [4] = '{4, 4, 1, 8};
  exp_t sbq [4][$];
  int total = 0, bad = 0, cyc = 0;
  function automatic exp_t mk(input logic [15:0] s, input logic co, ovf, zero);
    exp_t e;
    e.s = s; e.co = co; e.ovf = ovf; e.zero = zero; e.dc = 0;
    return e;
  endfunction
  function automatic exp_t model(input int w, input logic [15:0] a, b, input logic c, sb);
    logic [16:0] m, bb, cc, full, lo;
    exp_t e;
    m = (17'd1 << w) - 17'd1;
    bb = {1'b0, sb ? ~b : b} & m;
    cc = {16'd0, sb ? ~c : c};
    full = ({1'b0, a} & m) + bb + cc;
    lo = ({1'b0, a} & (m >> 1)) + (bb & (m >> 1)) + cc;
    e.s = full[15:0] & m[15:0];
    e.co = full[w];
    e.ovf = lo[w-1] ^ full[w];
    e.zero = e.s == 16'd0;
    e.dc = 0;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) if (dn[i]) begin
      if (sbq[i].size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done%0d got=1 want=0 (cycle %0d)", i, cyc);
      end else begin
        e = sbq[i].pop_front();
        chk($sformatf("res%0d", i), {13'd0, rs[i], rco[i], rov[i], rz[i]}, {13'd0, e.s, e.co, e.ovf, e.zero});
        chk($sformatf("done_cycle%0d", i), cyc, e.dc);
      end
    end
  endtask
  task automatic drive(input logic [3:0] m, input logic [15:0] a, b, input logic c, sb,
                       input int ex_i, input exp_t ex, input logic hold);
    exp_t e;
    st = m; ia = a; ib = b; ic = c; isb = sb;
    for (int i = 0; i < 4; i++) if (m[i]) begin
      e = (i == ex_i) ? ex : model(W[i], a, b, c, sb);
      e.dc = cyc + 1 + NC[i];
      sbq[i].push_back(e);
    end
    tick();
    if (!hold) st = '0;
  endtask
  task automatic wait_idle();
    logic ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 && sbq[3].size() == 0 && &rdy) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("idle_timeout", ok, 1);
  endtask
  vec_t tbl [6];
  initial begin
    exp_t e;
    int c0, n;
    tbl[0] = '{8'h3C, 8'h05, 0, 0, 8'h41, 0, 0, 0};
    tbl[1] = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1};
    tbl[2] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0};
    tbl[3] = '{8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 0};
    tbl[4] = '{8'h10, 8'h01, 1, 1, 8'h0E, 1, 0, 0};
    tbl[5] = '{8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 0};
    repeat (2) tick();
    chk("rst_s", rs[0], 0);
    chk("rst_flags", {rco[0], rov[0], rz[0]}, 0);
    chk("rst_ready", rdy, 4'hF);
    chk("rst_done", dn, 0);
    rst_n = 1;
    tick();
    for (int t = 0; t < 6; t++) begin
      drive(4'b0001, {8'h0, tbl[t].a}, {8'h0, tbl[t].b}, tbl[t].cin, tbl[t].sub, 0,
            mk({8'h0, tbl[t].s}, tbl[t].co, tbl[t].ovf, tbl[t].zero), 0);
      n = 0;
      for (int k = 0; k < 20 && !rdy[0]; k++) begin
        n++;
        tick();
      end
      chk($sformatf("ready_low%0d", t), n, 5);
      wait_idle();
    end
    drive(4'b0001, 16'h01, 16'h01, 0, 0, 0, mk(16'h02, 0, 0, 0), 1);
    ia = 16'hAA; ib = 16'h55;
    repeat (4) tick();
    st = '0;
    wait_idle();
    c0 = cyc;
    drive(4'b0001, 16'h11, 16'h22, 0, 0, 0, mk(16'h33, 0, 0, 0), 1);
    ia = 16'h40; ib = 16'h0F; isb = 1;
    e = mk(16'h31, 1, 0, 0);
    e.dc = c0 + 1 + 4 + 6;
    sbq[0].push_back(e);
    repeat (6) tick();
    st = '0;
    wait_idle();
    drive(4'b0001, 16'h33, 16'h11, 0, 0, 0, mk(16'h44, 0, 0, 0), 0);
    tick();
    #2 rst_n = 0;
    #1;
    chk("midrst_s", rs[0], 0);
    chk("midrst_flags", {rco[0], rov[0], rz[0]}, 0);
    chk("midrst_ready", rdy[0], 1);
    chk("midrst_done", dn[0], 0);
    sbq[0].delete();
    repeat (2) tick();
    rst_n = 1;
    repeat (8) tick();
    drive(4'b0001, 16'h3C, 16'h05, 0, 0, 0, mk(16'h41, 0, 0, 0), 0);
    wait_idle();
    drive(4'b0010, 16'hFFFF, 16'h0001, 1, 0, 1, mk(16'h0001, 1, 0, 0), 0);
    wait_idle();
    for (int r = 0; r < 1000; r++) begin
      drive(4'hF, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), -1, mk(0, 0, 0, 0), 0);
      wait_idle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
